line_buf_ctrl: RTL and testbench

Sequencer for the four-tap BRAM line-delay chain in the HDMI convolution filter. It derives the shared read/write address from incoming video timing, so that each BRAM stage delays exactly one full line (active plus blanking). It also generates the status bit that travels with the pixel data, and reports when the 5-line vertical window is fully populated. It sits between the HDMI receiver timing outputs and the line-delay block's `addr`/`stat_in` inputs.

---
 rtl/line_buf_pkg.sv | 14 +
 rtl/line_buf_ctrl_sync_edge_det.sv | 34 +++
 rtl/line_buf_ctrl.sv | 172 +++++++++++++++++
 tb/tb_line_buf_ctrl.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/line_buf_pkg.sv
// Shared definitions for the line-delay sequencer and the line-delay block.
package line_buf_pkg;

    localparam int ADDR_W_DEF = 12;
    localparam int TAPS_DEF   = 4;

    typedef enum logic [1:0] {
        SEARCH,
        MEASURE,
        VERIFY,
        LOCKED
    } lb_state_e;

endpackage

// File: rtl/line_buf_ctrl_sync_edge_det.sv
// Input register for a sync signal: normalises polarity to active-high and
// produces a one-cycle pulse when the registered signal becomes active.
module sync_edge_det #(
    parameter bit POL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic sig_in,
    output logic rise
);

    logic sig_q, sig_d;
    logic prev_q, prev_d;

    // Normalise to active-high on the way in and keep one cycle of history.
    always_comb begin
        sig_d  = (sig_in == POL);
        prev_d = sig_q;
    end

    // Input register plus history register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sig_q  <= 1'b0;
            prev_q <= 1'b0;
        end else begin
            sig_q  <= sig_d;
            prev_q <= prev_d;
        end
    end

    assign rise = sig_q & ~prev_q;

endmodule

// File: rtl/line_buf_ctrl.sv
// Address sequencer for the four-tap BRAM line-delay chain: measures the
// line period from hsync, locks onto it, free-runs the shared address, and
// tracks how many active lines are already stored in the delays.
module line_buf_ctrl
    import line_buf_pkg::*;
#(
    parameter int ADDR_W     = ADDR_W_DEF,
    parameter int TAPS       = TAPS_DEF,
    parameter int LOCK_LINES = 2,
    parameter bit HS_POL     = 1'b1,
    parameter bit VS_POL     = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              hsync_in,
    input  logic              vsync_in,
    input  logic              de_in,
    output logic [ADDR_W-1:0] addr,
    output logic              stat,
    output logic              locked,
    output logic [ADDR_W-1:0] htotal,
    output logic [ADDR_W-1:0] line_idx,
    output logic              win_valid,
    output logic              ovf
);

    localparam int MATCH_W = (LOCK_LINES > 1) ? $clog2(LOCK_LINES) + 1 : 1;
    localparam logic [ADDR_W-1:0]  A_ONE   = ADDR_W'(1);
    localparam logic [ADDR_W-1:0]  TAPS_A  = ADDR_W'(TAPS);
    localparam logic [MATCH_W-1:0] M_ONE   = MATCH_W'(1);
    localparam logic [MATCH_W-1:0] LOCK_M1 = MATCH_W'(LOCK_LINES - 1);

    logic hs_edge, vs_edge;

    logic              de_q, de_d, de_prev_q, de_prev_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d, cnt_inc;
    logic              ovf_q, ovf_d, ovf_evt;
    lb_state_e         state_q, state_d;
    logic [MATCH_W-1:0] match_q, match_d;
    logic [ADDR_W-1:0] htotal_q, htotal_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W-1:0] act_q, act_d;
    logic              hold_q, hold_d;
    logic              de_fall, lose;

    sync_edge_det #(.POL(HS_POL)) u_hs_det (
        .clk    (clk),
        .rst    (rst),
        .sig_in (hsync_in),
        .rise   (hs_edge)
    );

    sync_edge_det #(.POL(VS_POL)) u_vs_det (
        .clk    (clk),
        .rst    (rst),
        .sig_in (vsync_in),
        .rise   (vs_edge)
    );

    // Period counter restarts on each hsync edge; running into all-ones
    // without an edge means hsync has gone away.
    always_comb begin
        cnt_inc   = cnt_q + A_ONE;
        cnt_d     = hs_edge ? '0 : cnt_inc;
        ovf_evt   = (cnt_q == '1) && !hs_edge;
        ovf_d     = ovf_evt;
        de_d      = de_in;
        de_prev_d = de_q;
        de_fall   = de_prev_q & ~de_q;
    end

    // Lock FSM: measure one line, then require matching lines before trusting it.
    always_comb begin
        state_d  = state_q;
        htotal_d = htotal_q;
        match_d  = match_q;
        if (ovf_evt) begin
            state_d = SEARCH;
            match_d = '0;
        end else if (hs_edge) begin
            unique case (state_q)
                SEARCH: state_d = MEASURE;
                MEASURE: begin
                    htotal_d = cnt_inc;
                    match_d  = '0;
                    state_d  = VERIFY;
                end
                VERIFY: begin
                    if (cnt_inc == htotal_q) begin
                        match_d = match_q + M_ONE;
                        if (match_d >= LOCK_M1) begin
                            state_d = LOCKED;
                        end
                    end else begin
                        htotal_d = cnt_inc;
                        match_d  = '0;
                    end
                end
                LOCKED: begin
                    if (cnt_inc != htotal_q) begin
                        htotal_d = cnt_inc;
                        match_d  = '0;
                        state_d  = VERIFY;
                    end
                end
                default: state_d = SEARCH;
            endcase
        end
    end

    // Free-running modulo-htotal address once locked; otherwise track the counter.
    always_comb begin
        if (state_q == LOCKED) begin
            addr_d = (addr_q == htotal_q - A_ONE) ? '0 : addr_q + A_ONE;
        end else begin
            addr_d = cnt_d;
        end
    end

    // Active-line count: vsync restarts it, a lock loss zeroes and freezes it
    // until the next frame so a stale window is never reported.
    always_comb begin
        act_d  = act_q;
        hold_d = hold_q;
        lose   = (state_q == LOCKED) && (state_d != LOCKED);
        if (lose) begin
            act_d  = '0;
            hold_d = 1'b1;
        end else if (vs_edge) begin
            act_d  = '0;
            hold_d = 1'b0;
        end else if (de_fall && !hold_q && (act_q != '1)) begin
            act_d = act_q + A_ONE;
        end
    end

    // State registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            de_q      <= 1'b0;
            de_prev_q <= 1'b0;
            cnt_q     <= '0;
            ovf_q     <= 1'b0;
            state_q   <= SEARCH;
            match_q   <= '0;
            htotal_q  <= '0;
            addr_q    <= '0;
            act_q     <= '0;
            hold_q    <= 1'b0;
        end else begin
            de_q      <= de_d;
            de_prev_q <= de_prev_d;
            cnt_q     <= cnt_d;
            ovf_q     <= ovf_d;
            state_q   <= state_d;
            match_q   <= match_d;
            htotal_q  <= htotal_d;
            addr_q    <= addr_d;
            act_q     <= act_d;
            hold_q    <= hold_d;
        end
    end

    assign addr      = addr_q;
    assign stat      = de_q;
    assign locked    = (state_q == LOCKED);
    assign htotal    = htotal_q;
    assign line_idx  = act_q;
    assign ovf       = ovf_q;
    assign win_valid = locked & de_q & (act_q >= TAPS_A);

endmodule

// File: tb/tb_line_buf_ctrl.sv
// Scoreboard bench for line_buf_ctrl: stimulus schedules expected output
// values by cycle number, a monitor compares them as the cycles come up.
module tb_line_buf_ctrl;

    localparam int P = 1650;

    localparam int S_ADDR   = 0;
    localparam int S_STAT   = 1;
    localparam int S_LOCKED = 2;
    localparam int S_HTOT   = 3;
    localparam int S_LIDX   = 4;
    localparam int S_WIN    = 5;
    localparam int S_OVF    = 6;

    typedef struct {
        int          cyc;
        int          sel;
        logic [31:0] val;
        string       name;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        hsync_in;
    logic        vsync_in;
    logic        de_in;
    logic [11:0] addr;
    logic        stat;
    logic        locked;
    logic [11:0] htotal;
    logic [11:0] line_idx;
    logic        win_valid;
    logic        ovf;

    int   cyc;
    int   checks;
    int   errors;
    exp_t expQ[$];

    int s1, sV, s0, s, sL, sR, sM, sN, r;

    line_buf_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .hsync_in  (hsync_in),
        .vsync_in  (vsync_in),
        .de_in     (de_in),
        .addr      (addr),
        .stat      (stat),
        .locked    (locked),
        .htotal    (htotal),
        .line_idx  (line_idx),
        .win_valid (win_valid),
        .ovf       (ovf)
    );

    // Clock and cycle counter
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] actualOf(input int sel);
        case (sel)
            S_ADDR:   return 32'(addr);
            S_STAT:   return 32'(stat);
            S_LOCKED: return 32'(locked);
            S_HTOT:   return 32'(htotal);
            S_LIDX:   return 32'(line_idx);
            S_WIN:    return 32'(win_valid);
            default:  return 32'(ovf);
        endcase
    endfunction

    task automatic checkOutput(input string name, input int c, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s (cycle %0d): got %0d, expected %0d", name, c, act, exp);
        end
    endtask

    task automatic expectAt(input int c, input int sel, input logic [31:0] v, input string name);
        exp_t e;
        e.cyc  = c;
        e.sel  = sel;
        e.val  = v;
        e.name = name;
        expQ.push_back(e);
    endtask

    task automatic applyStimulus(input logic h, input logic v, input logic d);
        @(negedge clk);
        hsync_in = h;
        vsync_in = v;
        de_in    = d;
    endtask

    task automatic runLine(input int period, input logic deOn, input logic vsOn);
        for (int i = 0; i < period; i++)
            applyStimulus(i < 40, vsOn && (i >= 100) && (i < 110), deOn && (i >= 260) && (i < 1540));
    endtask

    // Monitor: compare every scheduled expectation due in this cycle.
    initial begin
        forever begin
            @(posedge clk);
            #2;
            for (int i = expQ.size() - 1; i >= 0; i--) begin
                if (expQ[i].cyc == cyc) begin
                    checkOutput(expQ[i].name, cyc, actualOf(expQ[i].sel), expQ[i].val);
                    expQ.delete(i);
                end
            end
        end
    end

    // Watchdog
    initial begin
        #800000;
        errors++;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        cyc      = 0;
        checks   = 0;
        errors   = 0;
        rst      = 1'b0;
        hsync_in = 1'b0;
        vsync_in = 1'b0;
        de_in    = 1'b0;

        // Reset held with random inputs: every output stays at zero.
        for (int k = 2; k <= 6; k++)
            for (int sel = 0; sel <= 6; sel++)
                expectAt(k, sel, 0, $sformatf("reset_out%0d", sel));
        for (int k = 0; k < 6; k++)
            applyStimulus(1'($urandom), 1'($urandom), 1'($urandom));
        r = cyc + 1;
        expectAt(r + 5, S_ADDR, 5, "release_addr_follows_cnt");
        expectAt(r + 5, S_LOCKED, 0, "release_unlocked");
        expectAt(r + 2, S_STAT, 0, "release_stat");
        applyStimulus(1'b0, 1'b0, 1'b0);
        rst = 1'b1;
        for (int k = 0; k < 20; k++) applyStimulus(1'b0, 1'b0, 1'b0);

        // 720p lines: lock after the third hsync edge, addr wraps on edges.
        s1 = cyc + 1;
        expectAt(s1 + 2, S_ADDR, 0, "unlocked_addr_clear_on_edge");
        expectAt(s1 + 260, S_STAT, 0, "stat_before_de");
        expectAt(s1 + 261, S_STAT, 1, "stat_latency");
        expectAt(s1 + P + 1, S_HTOT, 0, "htotal_before_measure");
        expectAt(s1 + P + 2, S_HTOT, P, "htotal_measured");
        expectAt(s1 + 2 * P + 1, S_LOCKED, 0, "locked_not_early");
        expectAt(s1 + 2 * P + 2, S_LOCKED, 1, "locked_after_3rd_edge");
        expectAt(s1 + 2 * P + 2, S_ADDR, 0, "addr_at_lock");
        for (int k = 3; k <= 4; k++) begin
            expectAt(s1 + k * P + 1, S_ADDR, P - 1, "addr_before_wrap");
            expectAt(s1 + k * P + 2, S_ADDR, 0, "addr_wrap_on_edge");
        end
        expectAt(s1 + 3 * P + 102, S_ADDR, 100, "addr_midline");
        for (int k = 0; k < 6; k++) runLine(P, 1'b1, 1'b0);

        // Vsync restarts the active-line count; window opens on line index 4.
        sV = cyc + 1;
        expectAt(sV + 101, S_LIDX, 6, "line_idx_before_vsync");
        expectAt(sV + 102, S_LIDX, 0, "line_idx_vsync_clear");
        for (int L = 0; L < 6; L++) begin
            expectAt(sV + (L + 1) * P + 260, S_WIN, 0, "win_before_de");
            expectAt(sV + (L + 1) * P + 261, S_WIN, (L >= 4) ? 1 : 0, "win_de_rise");
            expectAt(sV + (L + 1) * P + 1540, S_WIN, (L >= 4) ? 1 : 0, "win_de_last");
            expectAt(sV + (L + 1) * P + 1541, S_WIN, 0, "win_de_fall");
            expectAt(sV + (L + 1) * P + 1541, S_LIDX, L, "line_idx_before_fall");
            expectAt(sV + (L + 1) * P + 1542, S_LIDX, L + 1, "line_idx_after_fall");
        end
        runLine(P, 1'b0, 1'b1);
        for (int L = 0; L < 6; L++) runLine(P, 1'b1, 1'b0);

        // One long line while locked: lock drops, htotal remeasured, relock.
        s0 = cyc + 1;
        s  = s0 + P + 1;
        sL = s + 2 * P;
        expectAt(s0 + 261, S_WIN, 1, "win_long_line");
        expectAt(s + 1, S_LOCKED, 1, "locked_at_bad_edge");
        expectAt(s + 2, S_LOCKED, 0, "unlock_after_bad_edge");
        expectAt(s + 2, S_WIN, 0, "win_off_after_unlock");
        expectAt(s + 1, S_LIDX, 7, "line_idx_before_loss");
        expectAt(s + 2, S_LIDX, 0, "line_idx_cleared_on_loss");
        expectAt(s + 2, S_HTOT, P + 1, "htotal_1651");
        expectAt(s + P + 2, S_HTOT, P, "htotal_back_1650");
        expectAt(s + P + 2, S_LOCKED, 0, "still_unlocked");
        expectAt(s + 2 * P + 1, S_LOCKED, 0, "relock_not_early");
        expectAt(s + 2 * P + 2, S_LOCKED, 1, "relock");
        expectAt(sL + 261, S_WIN, 0, "win_held_off_until_vsync");
        expectAt(sL + 1542, S_LIDX, 0, "line_idx_held_until_vsync");

        // Hsync stops: single ovf pulse, lock lost, addr follows the counter.
        expectAt(sL + 4097, S_OVF, 0, "ovf_not_early");
        expectAt(sL + 4097, S_LOCKED, 1, "locked_before_ovf");
        expectAt(sL + 4098, S_OVF, 1, "ovf_pulse");
        expectAt(sL + 4098, S_LOCKED, 0, "unlocked_on_ovf");
        expectAt(sL + 4099, S_OVF, 0, "ovf_single_cycle");
        expectAt(sL + 4103, S_ADDR, 5, "addr_follows_cnt_after_ovf");
        runLine(P + 1, 1'b1, 1'b0);
        for (int k = 0; k < 3; k++) runLine(P, 1'b1, 1'b0);
        for (int k = 0; k < 4110 - P; k++) applyStimulus(1'b0, 1'b0, 1'b0);

        // Relock from SEARCH after the overflow.
        sR = cyc + 1;
        expectAt(sR + 2 * P + 1, S_LOCKED, 0, "ovf_relock_not_early");
        expectAt(sR + 2 * P + 2, S_LOCKED, 1, "ovf_relock");
        for (int k = 0; k < 3; k++) runLine(P, 1'b1, 1'b0);

        // Async reset mid-line while locked, then a full relock.
        sM = cyc + 1;
        sN = sM + P;
        expectAt(sM + 499, S_LOCKED, 1, "locked_before_reset");
        expectAt(sM + 502, S_LOCKED, 0, "reset_locked");
        expectAt(sM + 502, S_HTOT, 0, "reset_htotal");
        expectAt(sM + 508, S_ADDR, 3, "addr_after_midline_release");
        expectAt(sN + P + 1, S_HTOT, 0, "reset_htotal_before_measure");
        expectAt(sN + P + 2, S_HTOT, P, "reset_htotal_remeasured");
        expectAt(sN + 2 * P + 1, S_LOCKED, 0, "reset_relock_not_early");
        expectAt(sN + 2 * P + 2, S_LOCKED, 1, "reset_relock");
        for (int i = 0; i < P; i++) begin
            applyStimulus(i < 40, 1'b0, (i >= 260) && (i < 1540));
            if (i == 500) begin
                rst = 1'b0;
                #1;
                checkOutput("async_reset_locked", cyc, 32'(locked), 0);
                checkOutput("async_reset_addr", cyc, 32'(addr), 0);
                checkOutput("async_reset_htotal", cyc, 32'(htotal), 0);
                checkOutput("async_reset_stat", cyc, 32'(stat), 0);
                checkOutput("async_reset_win", cyc, 32'(win_valid), 0);
            end
            if (i == 505) rst = 1'b1;
        end
        for (int k = 0; k < 3; k++) runLine(P, 1'b1, 1'b0);
        for (int k = 0; k < 10; k++) applyStimulus(1'b0, 1'b0, 1'b0);

        // Any expectation never reached counts as a failure.
        foreach (expQ[i]) begin
            checks++;
            errors++;
            $display("[TB] FAIL %s: got no sample, expected check at cycle %0d", expQ[i].name, expQ[i].cyc);
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
